// File: rtl/window_shift_gen_pkg.sv
// Shared types and configuration checks for the sliding-window generator.
// Imported by the window register array and the top-level controller.
package window_shift_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_e;

  localparam int DATA_W_DEF = 8;

  function automatic bit cfg_ok(int k, int cols, int rows);
    return (k % 2 == 1) && (k >= 3) && (k <= 9) &&
           (cols >= k) && (rows >= k);
  endfunction

endpackage

// File: rtl/window_column_shifter.sv
// KxK pixel register array; each shift drops the oldest column
// and appends col_i as the newest (rightmost) column.
module window_column_shifter
  import window_shift_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_i,
  input  logic [K*DATA_W-1:0]   col_i,
  output logic [K*K*DATA_W-1:0] win_o
);

  localparam int RW = K * DATA_W;

  logic [K*K*DATA_W-1:0] win_q, win_d;

  // c=0 sits in the low bits of each row, so a left shift of
  // columns is a right shift of the row slice.
  always_comb begin
    win_d = win_q;
    if (shift_i) begin
      for (int r = 0; r < K; r++) begin
        win_d[r*RW +: RW] = {col_i[r*DATA_W +: DATA_W],
                             win_q[r*RW+DATA_W +: RW-DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else     win_q <= win_d;
  end

  assign win_o = win_q;

endmodule

// File: rtl/window_shift_gen.sv
// Sliding KxK window generator: counts columns/rows of incoming
// pixel columns and flags each complete in-row window.
module window_shift_gen
  import window_shift_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 9,
  parameter int COLS   = 11,
  parameter int ROWS   = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [K*DATA_W-1:0]      col_i,
  input  logic                     valid_i,
  input  logic                     done_i,
  output logic [K*K*DATA_W-1:0]    win_o,
  output logic                     valid_o,
  output logic [$clog2(COLS)-1:0]  col_idx_o,
  output logic [$clog2(ROWS)-1:0]  row_idx_o,
  output logic                     done_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [CW-1:0] KM1   = CW'(K - 1);
  localparam logic [CW-1:0] LASTC = CW'(COLS - 1);
  localparam logic [RW-1:0] LASTR = RW'(ROWS - K);

  if (!cfg_ok(K, COLS, ROWS)) begin : g_cfg_err
    $error("window_shift_gen: K must be odd 3..9, COLS/ROWS >= K");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          acc;

  // an abort in the same cycle discards the column
  assign acc = valid_i & ~done_i;

  window_column_shifter #(
    .DATA_W (DATA_W),
    .K      (K)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_i (acc),
    .col_i   (col_i),
    .win_o   (win_o)
  );

  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    row_d     = row_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (done_i) begin
      state_d   = IDLE;
      in_col_d  = '0;
      row_d     = '0;
      col_idx_d = '0;
      row_idx_d = '0;
    end else if (acc) begin
      in_col_d = in_col_q + 1'b1;
      if (in_col_q >= KM1) begin
        valid_d   = 1'b1;
        col_idx_d = in_col_q - KM1;
        row_idx_d = row_q;
      end
      if (in_col_q == LASTC) begin
        in_col_d = '0;
        if (row_q == LASTR) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      unique case (state_q)
        IDLE, DONE: state_d = FILL;
        FILL: if ((in_col_q + 1'b1) == KM1) state_d = RUN;
        RUN: begin
          if (in_col_q == LASTC)
            state_d = (row_q == LASTR) ? DONE : FILL;
        end
      endcase
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_col_q  <= '0;
      row_q     <= '0;
      col_idx_q <= '0;
      row_idx_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      row_q     <= row_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign valid_o   = valid_q;
  assign col_idx_o = col_idx_q;
  assign row_idx_o = row_idx_q;
  assign done_o    = done_q;

endmodule
